// File: rtl/acc_cpu_core.sv
// acc_cpu_core: accumulator CPU core sequencing FETCH/DECODE/MEM/HALT over a req/ack memory port.
// Define ACC_CPU_SUB_EN to enable opcode 8 (SUB, ac <= ac - M); otherwise opcode 8 is illegal.
module acc_cpu_core #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 28,
    parameter int unsigned RESET_PC   = 'h100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac,
    output logic                  retire,
    output logic                  halted,
    output logic                  illegal
);
`ifdef ACC_CPU_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    typedef enum logic [1:0] {FETCH, DECODE, MEM, HALT} state_t;
    localparam logic [3:0] OP_ADD = 4'd0, OP_HALT = 4'd1, OP_LOAD = 4'd2, OP_STORE = 4'd3,
                           OP_CLEAR = 4'd4, OP_SKIP = 4'd5, OP_JUMP = 4'd6, OP_ADDI = 4'd7,
                           OP_SUB = 4'd8;
    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] ir, ir_n, ac_n, imm;
    logic [ADDR_WIDTH-1:0] pc_n, operand;
    logic [3:0]            op;
    logic                  pend, pend_n, illegal_n, req, skip, is_mem;
    assign op        = ir[DATA_WIDTH-1 -: 4];
    assign operand   = ir[ADDR_WIDTH-1:0];
    assign imm       = {{(DATA_WIDTH-12){ir[11]}}, ir[11:0]};
    assign skip      = ir[2:0] == 3'b000 ? ac[DATA_WIDTH-1] :
                       ir[2:0] == 3'b010 ? ac == '0 :
                       ir[2:0] == 3'b100 ? (!ac[DATA_WIDTH-1] && ac != '0) : 1'b0;
    assign is_mem    = op == OP_ADD || op == OP_LOAD || op == OP_STORE || (SUB_EN && op == OP_SUB);
    // Reset must drop the request combinationally, even with run held high.
    assign mem_req   = req && rst_n;
    assign mem_wdata = ac;
    assign halted    = state == HALT;
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ac_n      = ac;
        ir_n      = ir;
        illegal_n = illegal;
        pend_n    = 1'b0;
        req       = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                // pend keeps an unacknowledged fetch alive after run drops
                req    = run || pend;
                pend_n = req && !mem_ack;
                if (req && mem_ack) begin
                    ir_n    = mem_rdata;
                    pc_n    = pc + ADDR_WIDTH'(1);
                    state_n = DECODE;
                end
            end
            DECODE: begin
                state_n = FETCH;
                retire  = 1'b1;
                if (is_mem) begin
                    state_n = MEM;
                    retire  = 1'b0;
                end else begin
                    case (op)
                        OP_CLEAR: ac_n = '0;
                        OP_SKIP:  pc_n = skip ? pc + ADDR_WIDTH'(1) : pc;
                        OP_JUMP:  pc_n = operand;
                        OP_ADDI:  ac_n = ac + imm;
                        OP_HALT:  state_n = HALT;
                        default: begin
                            state_n   = HALT;
                            retire    = 1'b0;
                            illegal_n = 1'b1;
                        end
                    endcase
                end
            end
            MEM: begin
                req      = 1'b1;
                mem_addr = operand;
                mem_we   = op == OP_STORE;
                if (mem_ack) begin
                    ac_n    = op == OP_LOAD ? mem_rdata :
                              op == OP_ADD  ? ac + mem_rdata :
                              op == OP_SUB  ? ac - mem_rdata : ac;
                    retire  = 1'b1;
                    state_n = FETCH;
                end
            end
            HALT: state_n = HALT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= ADDR_WIDTH'(RESET_PC);
            ac      <= '0;
            ir      <= '0;
            pend    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            ac      <= ac_n;
            ir      <= ir_n;
            pend    <= pend_n;
            illegal <= illegal_n;
        end
    end
endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: scoreboard bench; a memory responder serves requests, a monitor checks bus traffic.
module tb_acc_cpu_core;
    logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req, mem_we, retire, halted, illegal;
    logic [27:0] mem_addr, pc;
    logic [31:0] mem_wdata, ac;

    acc_cpu_core dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .ac(ac), .retire(retire), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic we; logic [27:0] addr; logic [31:0] data;} txn_t;
    txn_t        exp_q[$];
    int          n_cmp = 0, n_err = 0, retires = 0, store_delay = 0, cyc = 0, k = 0;
    logic [31:0] mem [0:1023];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [27:0] arg);
        return {op, arg};
    endfunction

    function automatic void push(input logic we, input logic [27:0] addr, input logic [31:0] data);
        exp_q.push_back('{we: we, addr: addr, data: data});
    endfunction

    function automatic void push_reads(input int unsigned a0, a1, a2, a3);
        push(1'b0, 28'(a0), '0);
        if (a1 != 0) push(1'b0, 28'(a1), '0);
        if (a2 != 0) push(1'b0, 28'(a2), '0);
        if (a3 != 0) push(1'b0, 28'(a3), '0);
    endfunction

    // Memory responder: decides ack at negedge, commits a granted write at the next negedge.
    int          wc = 0;
    bit          granted = 0;
    logic        g_we;
    logic [27:0] g_addr;
    logic [31:0] g_wdata;
    always @(negedge clk) begin
        if (!rst_n) granted = 0;
        if (granted) begin
            if (g_we) mem[g_addr[9:0]] = g_wdata;
            granted = 0;
            wc = 0;
        end
        if (!mem_req) begin
            mem_ack = 1'b0;
            wc = 0;
        end else if (wc >= (mem_we ? store_delay : 0)) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr[9:0]];
            granted   = 1;
            g_we      = mem_we;
            g_addr    = mem_addr;
            g_wdata   = mem_wdata;
        end else begin
            mem_ack = 1'b0;
            wc++;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks held requests stay stable.
    logic        prev_wait = 1'b0, p_we;
    logic [27:0] p_addr;
    logic [31:0] p_wdata;
    always @(negedge clk) begin
        #2;
        if (!rst_n) prev_wait = 1'b0;
        else begin
            if (retire) retires++;
            if (mem_req && prev_wait) begin
                chk("hold_addr", 64'(mem_addr), 64'(p_addr));
                chk("hold_we", 64'(mem_we), 64'(p_we));
                chk("hold_wdata", 64'(mem_wdata), 64'(p_wdata));
            end
            if (mem_req && mem_ack) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL txn_unexpected: got addr %0h we %0b, expected none", mem_addr, mem_we);
                end else begin
                    txn_t e;
                    e = exp_q.pop_front();
                    chk("txn_addr", 64'(mem_addr), 64'(e.addr));
                    chk("txn_we", 64'(mem_we), 64'(e.we));
                    if (e.we) chk("txn_wdata", 64'(mem_wdata), 64'(e.data));
                end
            end
            prev_wait = mem_req && !mem_ack;
            p_addr    = mem_addr;
            p_we      = mem_we;
            p_wdata   = mem_wdata;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk("rst_pc", 64'(pc), 64'h100);
        chk("rst_ac", 64'(ac), 64'h0);
        chk("rst_req", 64'(mem_req), 64'h0);
        chk("rst_retire", 64'(retire), 64'h0);
        chk("rst_halted", 64'(halted), 64'h0);
        chk("rst_illegal", 64'(illegal), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        retires = 0;
        exp_q.delete();
        @(negedge clk);
        #3;
        chk("idle_req", 64'(mem_req), 64'h0);
    endtask

    task automatic run_prog(input int budget, output int cycles);
        @(posedge clk);
        #1 run = 1'b1;
        #1;
        chk("first_req", 64'(mem_req), 64'h1);
        chk("first_addr", 64'(mem_addr), 64'h100);
        chk("first_we", 64'(mem_we), 64'h0);
        cycles = 0;
        while (!halted && cycles < budget) begin
            @(posedge clk);
            #1 cycles++;
        end
        chk("halt_reached", 64'(halted), 64'h1);
        @(negedge clk);
        #4;
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic load_p1();
        clear_mem();
        mem['h100] = ins(4'd2, 28'h110);
        mem['h101] = ins(4'd7, 28'd3);
        mem['h102] = ins(4'd3, 28'h111);
        mem['h103] = ins(4'd1, 28'h0);
        mem['h110] = 32'd5;
        push_reads('h100, 'h110, 'h101, 'h102);
        push(1'b1, 28'h111, 32'd8);
        push_reads('h103, 0, 0, 0);
    endtask

    initial begin
        clear_mem();
        // LOAD/ADDI/STORE/HALT with zero-wait memory
        do_reset();
        load_p1();
        run_prog(50, cyc);
        chk("p1_cycles", 64'(cyc), 64'd10);
        chk("p1_store", 64'(mem['h111]), 64'd8);
        chk("p1_retires", 64'(retires), 64'd4);
        chk("p1_pc", 64'(pc), 64'h104);
        chk("p1_ac", 64'(ac), 64'd8);
        chk("p1_illegal", 64'(illegal), 64'h0);
        // Same program with the store acknowledged after 3 wait cycles
        do_reset();
        load_p1();
        store_delay = 3;
        run_prog(50, cyc);
        store_delay = 0;
        chk("p2_cycles", 64'(cyc), 64'd13);
        chk("p2_store", 64'(mem['h111]), 64'd8);
        chk("p2_retires", 64'(retires), 64'd4);
        // SKIP on zero
        do_reset();
        clear_mem();
        mem['h100] = ins(4'd5, 28'd2);
        mem['h102] = ins(4'd1, 28'h0);
        push_reads('h100, 'h102, 0, 0);
        run_prog(50, cyc);
        chk("p3_pc", 64'(pc), 64'h103);
        chk("p3_retires", 64'(retires), 64'd2);
        // ADDI -1, SKIP on positive (no skip), SKIP on negative (skips)
        do_reset();
        clear_mem();
        mem['h100] = ins(4'd7, 28'hFFF);
        mem['h101] = ins(4'd5, 28'd4);
        mem['h102] = ins(4'd5, 28'd0);
        mem['h104] = ins(4'd1, 28'h0);
        push_reads('h100, 'h101, 'h102, 'h104);
        run_prog(50, cyc);
        chk("p4_ac", 64'(ac), 64'hFFFF_FFFF);
        chk("p4_pc", 64'(pc), 64'h105);
        chk("p4_retires", 64'(retires), 64'd4);
        // JUMP, ADD with wraparound, STORE result, CLEAR
        do_reset();
        clear_mem();
        mem['h100] = ins(4'd2, 28'h110);
        mem['h101] = ins(4'd6, 28'h120);
        mem['h120] = ins(4'd0, 28'h110);
        mem['h121] = ins(4'd0, 28'h111);
        mem['h122] = ins(4'd3, 28'h112);
        mem['h123] = ins(4'd4, 28'h0);
        mem['h124] = ins(4'd1, 28'h0);
        mem['h110] = 32'd5;
        mem['h111] = 32'hFFFF_FFFA;
        push_reads('h100, 'h110, 'h101, 'h120);
        push_reads('h110, 'h121, 'h111, 'h122);
        push(1'b1, 28'h112, 32'd4);
        push_reads('h123, 'h124, 0, 0);
        run_prog(80, cyc);
        chk("p5_store", 64'(mem['h112]), 64'd4);
        chk("p5_ac", 64'(ac), 64'h0);
        chk("p5_pc", 64'(pc), 64'h125);
        chk("p5_retires", 64'(retires), 64'd7);
        // Opcode 8: SUB when enabled, illegal otherwise
        do_reset();
        clear_mem();
        mem['h100] = ins(4'd2, 28'h110);
        mem['h101] = ins(4'd8, 28'h111);
        mem['h102] = ins(4'd1, 28'h0);
        mem['h110] = 32'd7;
        mem['h111] = 32'd2;
        push_reads('h100, 'h110, 'h101, 0);
`ifdef ACC_CPU_SUB_EN
        push_reads('h111, 'h102, 0, 0);
        run_prog(50, cyc);
        chk("p6_ac", 64'(ac), 64'd5);
        chk("p6_illegal", 64'(illegal), 64'h0);
        chk("p6_retires", 64'(retires), 64'd3);
        chk("p6_pc", 64'(pc), 64'h103);
`else
        run_prog(50, cyc);
        chk("p6_ac", 64'(ac), 64'd7);
        chk("p6_illegal", 64'(illegal), 64'h1);
        chk("p6_retires", 64'(retires), 64'd1);
        chk("p6_pc", 64'(pc), 64'h102);
`endif
        // Reset while a store request is held
        do_reset();
        clear_mem();
        mem['h100] = ins(4'd7, 28'd9);
        mem['h101] = ins(4'd3, 28'h111);
        push_reads('h100, 'h101, 0, 0);
        store_delay = 1000;
        @(posedge clk);
        #1 run = 1'b1;
        k = 0;
        while (!(mem_req && mem_we) && k < 20) begin
            @(posedge clk);
            #1 k++;
        end
        chk("p7_store_pending", 64'(mem_req && mem_we), 64'h1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("p7_req_drop", 64'(mem_req), 64'h0);
        chk("p7_ac", 64'(ac), 64'h0);
        chk("p7_pc", 64'(pc), 64'h100);
        run = 1'b0;
        store_delay = 0;
        chk("p7_queue", 64'(exp_q.size()), 64'h0);
        do_reset();
        chk("p7_abandoned", 64'(mem['h111]), 64'h0);
        mem['h100] = ins(4'd1, 28'h0);
        push_reads('h100, 0, 0, 0);
        run_prog(50, cyc);
        chk("p7_pc_after", 64'(pc), 64'h101);
        chk("p7_retires", 64'(retires), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/acc_cpu_core.md
ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 Parameter DATA_WIDTH, default 32, accumulator/memory word width, legal range 16..64.
REQ-002 Parameter ADDR_WIDTH, default 28, memory word-address width, SHALL be <= DATA_WIDTH-4.
REQ-003 Parameter RESET_PC, default 'h100, program counter value after reset.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  when high, core may begin a new fetch; low holds core in FETCH with mem_req=0.
REQ-007 mem_req  output  1  memory request, held until accepted.
REQ-008 mem_we  output  1  1=write, 0=read; valid while mem_req=1.
REQ-009 mem_addr  output  ADDR_WIDTH  word address; valid while mem_req=1.
REQ-010 mem_wdata  output  DATA_WIDTH  store data; valid while mem_req=1 and mem_we=1.
REQ-011 mem_rdata  input  DATA_WIDTH  read data, sampled on the edge where mem_req=1 and mem_ack=1.
REQ-012 mem_ack  input  1  request accepted/completed this cycle; ignored when mem_req=0.
REQ-013 pc  output  ADDR_WIDTH  current program counter.
REQ-014 ac  output  DATA_WIDTH  current accumulator.
REQ-015 retire  output  1  one-cycle pulse when an instruction completes.
REQ-016 halted  output  1  high in HALT state.
REQ-017 illegal  output  1  sticky; set when an undefined opcode is decoded.

Function
REQ-018 Instruction format: opcode = IR[DATA_WIDTH-1:DATA_WIDTH-4]; operand address = IR[ADDR_WIDTH-1:0].
REQ-019 States: FETCH, DECODE, MEM, HALT; transitions below only.
REQ-020 FETCH: if run=1, mem_req=1, mem_we=0, mem_addr=pc; on ack IR<=mem_rdata, pc<=pc+1 mod 2^ADDR_WIDTH, go DECODE.
REQ-021 Opcodes: 0 ADD (ac<=ac+M), 2 LOAD (ac<=M), 3 STORE (M<=ac), 4 CLEAR, 5 SKIP, 6 JUMP (pc<=operand), 7 ADDI, 1 HALT.
REQ-022 ADD/LOAD/STORE: DECODE->MEM; MEM holds mem_req, mem_addr=operand, mem_we=(STORE), mem_wdata=ac until ack; on ack update ac (reads), pulse retire, go FETCH.
REQ-023 CLEAR/SKIP/JUMP/ADDI complete in DECODE: update state, pulse retire, go FETCH.
REQ-024 ADDI: ac<=ac+sign-extended IR[11:0].
REQ-025 SKIP cond IR[2:0]: 000 ac<0 (signed), 010 ac==0, 100 ac>0 (signed); if true pc<=pc+1 (wraps); other codes never skip.
REQ-026 All arithmetic modulo 2^DATA_WIDTH; overflow discarded, no flag.
REQ-027 HALT or undefined opcode: go HALT, pulse retire (HALT only), halted=1; undefined also sets illegal; HALT exits only via reset.
REQ-028 Minimum latency with same-cycle ack: 3 cycles ADD/LOAD/STORE, 2 cycles others; each extra wait cycle on ack adds one.
REQ-029 mem_addr, mem_we, mem_wdata SHALL not change while mem_req=1 and mem_ack=0.
REQ-030 run falling while a fetch request is outstanding: request held until ack (no abort).

Reset
REQ-031 rst_n=0: immediately state=FETCH, pc=RESET_PC, ac=0, IR=0, mem_req=0, mem_we=0, retire=0, halted=0, illegal=0.
REQ-032 Reset mid-request drops mem_req asynchronously; outstanding transaction is abandoned, no state update.

Configuration
REQ-033 Macro ACC_CPU_SUB_EN defined: opcode 8 SUB (ac<=ac-M) via MEM state, same timing as ADD.
REQ-034 Macro ACC_CPU_SUB_EN undefined: opcode 8 is undefined and handled per REQ-027.

Verification
REQ-035 Reset release, run=1 -> first mem_req with mem_addr=0x100, mem_we=0; pc=0x100, ac=0 before.
REQ-036 Program LOAD 0x110 (M=5), ADDI 3, STORE 0x111, HALT, same-cycle ack -> M[0x111]=8, 4 retire pulses, halted=1, pc=0x104.
REQ-037 ac=0 then SKIP 010 at 0x100 -> next fetch address 0x102; with ac=-1 and SKIP 100 -> 0x101.
REQ-038 ack delayed 3 cycles on a STORE -> mem_addr/mem_we/mem_wdata stable all 4 request cycles, instruction takes 6 cycles.
REQ-039 Opcode 8 with M=2, ac=7 -> ac=5 with ACC_CPU_SUB_EN; without it halted=1, illegal=1, no retire.
REQ-040 rst_n low during held MEM request -> mem_req=0 same cycle; after release fetch restarts at 0x100, ac=0.
